uart_echo_bridge: RTL

- Parametrised successor to the single-byte UART echo loop.
- Sits between the uart core's RX FIFO read port and TX write port, in the same clock domain as the uart.
- Two runtime modes:
  - passthrough: every received byte is echoed back immediately.
  - line mode: bytes are buffered, with backspace editing, and the whole line is echoed on a terminator or when the buffer fills.
- Honours TX back-pressure; the original loop did not.

---
 rtl/echo_pkg.sv | 20 ++
 rtl/echo_line_buf.sv | 66 ++++++
 rtl/uart_echo_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared types and ASCII constants for the UART echo bridge.
package echo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAP,
        SEND,
        DRAIN
    } state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

endpackage

// File: rtl/echo_line_buf.sv
// Line buffer: DEPTH x DATA_W storage with fill count and drain read index.
module echo_line_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_last_i,
    input  logic              read_next_i,
    input  logic              clear_i,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              empty_nxt_o,
    output logic              last_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     rd_q, rd_d;

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        if (clear_i) begin
            cnt_d = '0;
            rd_d  = '0;
        end else begin
            if (push_i)
                cnt_d = cnt_q + CW'(1);
            else if (pop_last_i && (cnt_q != '0))
                cnt_d = cnt_q - CW'(1);
            if (read_next_i)
                rd_d = rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

    // Lines always fill from index 0, so the write slot is the count itself.
    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[cnt_q[AW-1:0]] <= data_i;
    end

    assign count_o     = cnt_q;
    assign full_o      = (cnt_q == CW'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign empty_nxt_o = (cnt_d == '0);
    assign last_o      = ((CW'(rd_q) + CW'(1)) == cnt_q);
    assign head_o      = mem_q[rd_q];

endmodule

// File: rtl/uart_echo_bridge.sv
// UART echo bridge: passthrough or line-edited echo between RX FIFO and TX FIFO.
// Build option ECHO_UPCASE_EN: fold lowercase ASCII to uppercase at capture.
//   state | meaning
//   IDLE  | wait for RX data; latch mode when line buffer empty
//   POP   | rx_read strobe high
//   CAP   | capture rx_byte; edit/push line or head for SEND
//   SEND  | passthrough byte waiting for TX space
//   DRAIN | emit buffered line in order, honouring tx_full
module uart_echo_bridge
    import echo_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 32,
    parameter logic [DATA_W-1:0] TERM   = DATA_W'(CR),
    parameter logic [DATA_W-1:0] BKSP   = DATA_W'(BS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_mode,
    input  logic              rx_ready,
    output logic              rx_read,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              tx_full,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE_SHORT = CW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              rx_read_q, rx_read_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] cap_byte;

    logic              buf_push, buf_pop_last, buf_read_next, buf_clear;
    logic [CW-1:0]     buf_count;
    logic              buf_full, buf_empty, buf_empty_nxt, buf_last;
    logic [DATA_W-1:0] buf_head;

`ifdef ECHO_UPCASE_EN
    always_comb begin
        cap_byte = rx_byte;
        if (is_lower(rx_byte[7:0]) && ((rx_byte >> 8) == '0))
            cap_byte[5] = 1'b0;
    end
`else
    assign cap_byte = rx_byte;
`endif

    echo_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_line_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (buf_push),
        .data_i      (cap_byte),
        .pop_last_i  (buf_pop_last),
        .read_next_i (buf_read_next),
        .clear_i     (buf_clear),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .empty_nxt_o (buf_empty_nxt),
        .last_o      (buf_last),
        .head_o      (buf_head)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cap_d         = cap_q;
        rx_read_d     = 1'b0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        buf_push      = 1'b0;
        buf_pop_last  = 1'b0;
        buf_read_next = 1'b0;
        buf_clear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_empty)
                    mode_d = line_mode;
                if (rx_ready) begin
                    state_d   = POP;
                    rx_read_d = 1'b1;
                end
            end
            POP: state_d = CAP;
            CAP: begin
                cap_d = cap_byte;
                if (!mode_q) begin
                    state_d = SEND;
                end else if (cap_byte == BKSP) begin
                    buf_pop_last = !buf_empty;
                    state_d      = IDLE;
                end else begin
                    buf_push = !buf_full;
                    // Reaching DEPTH forces a drain, so the buffer never overflows.
                    if ((cap_byte == TERM) || (buf_count == ONE_SHORT))
                        state_d = DRAIN;
                    else
                        state_d = IDLE;
                end
            end
            SEND: begin
                if (!tx_full) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cap_q;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (!tx_full) begin
                    tx_start_d    = 1'b1;
                    tx_data_d     = buf_head;
                    buf_read_next = 1'b1;
                    if (buf_last) begin
                        buf_clear = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || !buf_empty_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            cap_q      <= '0;
            rx_read_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cap_q      <= cap_d;
            rx_read_q  <= rx_read_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_read  = rx_read_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;

endmodule
